// File: rtl/spi_axis_bridge.sv
// rtl/spi_axis_bridge.sv - SPI mode-0 slave to byte-wide AXI-Stream bridge with TX response FIFO.
// Optional macro SPI_AXIS_TX_FLUSH_EN: empty the TX FIFO on every armed CS rise.
module spi_axis_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TX_DEPTH    = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_spi_sclk,
    input  logic       i_spi_cs_n,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tkeep,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tkeep,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       o_rx_active
);
    localparam int AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {
        S_UNARMED,
        S_IDLE,
        S_ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic [SYNC_STAGES:0]   r_settle;

    state_t     r_state;
    state_t     w_state_next;

    logic [2:0] r_bit_cnt;
    logic       r_bad;
    logic       r_first_fall;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_pending;
    logic       r_pending_valid;

    logic [7:0]  r_fifo [TX_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic       w_sclk;
    logic       w_cs;
    logic       w_mosi;
    logic       w_settled;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_frame_on;
    logic       w_full;
    logic       w_empty;
    logic       w_fifo_wr;
    logic       w_tx_load;
    logic       w_pop;
    logic [7:0] w_tx_next;
    logic [7:0] w_rx_byte;
    logic       w_byte_done;
    logic       w_push;
    logic       w_push_last;
    logic       w_push_user;
    logic       w_out_free;
    logic       w_drop;
    logic       w_unused;

    assign w_unused = &{1'b0, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_settle    <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    // The chain resets to cs_n=1, so only trust it once real pin values have flushed through.
    assign w_settled = r_settle[SYNC_STAGES];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_UNARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cs_fall    = 1'b0;
        w_cs_rise    = 1'b0;
        w_sclk_rise  = 1'b0;
        w_sclk_fall  = 1'b0;
        w_frame_on   = 1'b0;
        case (r_state)
            S_UNARMED: begin
                if (w_settled && w_cs) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!w_cs) begin
                    w_cs_fall    = 1'b1;
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_cs) begin
                    w_cs_rise    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_frame_on  = 1'b1;
                    w_sclk_rise = w_sclk && !r_sclk_hist;
                    w_sclk_fall = !w_sclk && r_sclk_hist;
                end
            end
            default: w_state_next = S_UNARMED;
        endcase
    end

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign s_axis_tready = !i_reset && !w_full;
    assign w_fifo_wr = s_axis_tvalid && s_axis_tready;

    assign w_tx_load = w_cs_fall || (w_sclk_fall && (r_bit_cnt == 3'd0) && !r_first_fall);
    assign w_pop     = w_tx_load && !w_empty;
    assign w_tx_next = w_empty ? 8'hFF : r_fifo[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_fifo_wr) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
`ifdef SPI_AXIS_TX_FLUSH_EN
            if (w_cs_rise) begin
                r_rd_ptr <= r_wr_ptr;
            end
`endif
        end
    end

    assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    // A completed byte is held back one slot so the final byte of a frame can carry tlast.
    assign w_push      = r_pending_valid && (w_byte_done || w_cs_rise);
    assign w_push_last = w_cs_rise;
    assign w_push_user = w_cs_rise && (r_bad || (r_bit_cnt != 3'd0));
    assign w_out_free  = !m_axis_tvalid || m_axis_tready;
    assign w_drop      = w_push && !w_out_free;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bit_cnt       <= 3'd0;
            r_bad           <= 1'b0;
            r_first_fall    <= 1'b0;
            r_rx_shift      <= 8'h00;
            r_tx_shift      <= 8'hFF;
            r_pending       <= 8'h00;
            r_pending_valid <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_bit_cnt       <= 3'd0;
                r_bad           <= 1'b0;
                r_first_fall    <= 1'b1;
                r_pending_valid <= 1'b0;
            end else begin
                if (w_drop || (w_cs_rise && (r_bit_cnt != 3'd0))) begin
                    r_bad <= 1'b1;
                end
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_byte;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                if (w_sclk_fall) begin
                    r_first_fall <= 1'b0;
                end
                if (w_byte_done) begin
                    r_pending       <= w_rx_byte;
                    r_pending_valid <= 1'b1;
                end else if (w_cs_rise) begin
                    r_pending_valid <= 1'b0;
                end
            end
            if (w_tx_load) begin
                r_tx_shift <= w_tx_next;
            end else if (w_sclk_fall) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (w_push && w_out_free) begin
            m_axis_tdata  <= r_pending;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= w_push_last;
            m_axis_tuser  <= w_push_user;
        end else begin
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            // A frame end that cannot be queued closes the frame through the stalled beat.
            if (w_drop && w_push_last) begin
                m_axis_tlast <= 1'b1;
                m_axis_tuser <= 1'b1;
            end
        end
    end

    assign m_axis_tkeep = 1'b1;
    assign o_rx_active  = w_frame_on;
    assign o_spi_miso   = w_frame_on ? r_tx_shift[7] : 1'b1;

endmodule

// File: tb/tb_spi_axis_bridge.sv
// tb/tb_spi_axis_bridge.sv - randomized self-checking bench for spi_axis_bridge against a frame-level model.
module tb_spi_axis_bridge;
    localparam int SYNC  = 2;
    localparam int DEPTH = 16;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] m_tdata;
    logic       m_tkeep;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       m_tlast;
    logic       m_tuser;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic       rx_active;

    spi_axis_bridge #(.SYNC_STAGES(SYNC), .TX_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_spi_sclk    (sclk),
        .i_spi_cs_n    (cs_n),
        .i_spi_mosi    (mosi),
        .o_spi_miso    (miso),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (1'b1),
        .s_axis_tlast  (1'b0),
        .s_axis_tuser  (1'b0),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .o_rx_active   (rx_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] tx_q [$];
    logic [9:0] beats [$];
    logic [7:0] f_mosi   [0:7];
    logic [7:0] f_miso   [0:7];
    logic [7:0] exp_miso [0:7];
    logic       watch_rdy = 1'b0;
    int         rdy_drops = 0;

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) beats.push_back({m_tlast, m_tuser, m_tdata});
        if (watch_rdy && !s_tready) rdy_drops++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        tx_q.delete();
        wait_cyc(8);
    endtask

    task automatic push_tx(input logic [7:0] b);
        s_tdata  = b;
        s_tvalid = 1'b1;
        wait_cyc(1);
        s_tvalid = 1'b0;
        tx_q.push_back(b);
    endtask

    // Each frame loads the TX register once at CS fall and once after every full byte.
    task automatic model_pops(input int nfull);
        logic [7:0] b;
        for (int k = 0; k <= nfull; k++) begin
            if (tx_q.size() > 0) b = tx_q.pop_front();
            else b = 8'hFF;
            if (k < 8) exp_miso[k] = b;
        end
`ifdef SPI_AXIS_TX_FLUSH_EN
        tx_q.delete();
`endif
    endtask

    task automatic spi_bits(input int nfull, input int npart);
        logic [7:0] b;
        int nb;
        for (int k = 0; k < nfull + ((npart > 0) ? 1 : 0); k++) begin
            nb = (k < nfull) ? 8 : npart;
            b = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi = f_mosi[k][7-i];
                wait_cyc(HALF);
                b = {b[6:0], miso};
                sclk = 1'b1;
                wait_cyc(HALF);
                sclk = 1'b0;
            end
            if (k < nfull) f_miso[k] = b;
        end
    endtask

    task automatic spi_frame(input int nfull, input int npart);
        cs_n = 1'b0;
        wait_cyc(HALF);
        spi_bits(nfull, npart);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic run_frame(input int nfull, input int npart, input string tag);
        logic [9:0] e;
        model_pops(nfull);
        beats.delete();
        spi_frame(nfull, npart);
        check_eq({tag, " beats"}, beats.size(), nfull);
        for (int k = 0; k < nfull; k++) begin
            e = {(k == nfull - 1), ((k == nfull - 1) && (npart > 0)), f_mosi[k]};
            if (k < beats.size()) check_eq({tag, " beat"}, beats[k], e);
            check_eq({tag, " miso"}, f_miso[k], exp_miso[k]);
        end
    endtask

    initial begin
        int lat;
        int nf;
        int np;
        wait_cyc(3);
        check_eq("rst tvalid", m_tvalid, 0);
        check_eq("rst tdata", m_tdata, 0);
        check_eq("rst tlast", {m_tlast, m_tuser}, 0);
        check_eq("rst miso", miso, 1);
        check_eq("rst rx_active", rx_active, 0);
        check_eq("rst s_tready", s_tready, 0);
        check_eq("tkeep", m_tkeep, 1);
        rst = 1'b0;
        wait_cyc(1);
        check_eq("s_tready after rst", s_tready, 1);
        wait_cyc(8);

        f_mosi[0] = 8'hA5; f_mosi[1] = 8'h01; f_mosi[2] = 8'h7E;
        run_frame(3, 0, "three_byte");

        push_tx(8'h3C);
        push_tx(8'hC3);
        watch_rdy = 1'b1;
        rdy_drops = 0;
        for (int k = 0; k < 3; k++) f_mosi[k] = 8'($urandom);
        run_frame(3, 0, "response");
        watch_rdy = 1'b0;
        check_eq("resp tready drops", rdy_drops, 0);

        f_mosi[0] = 8'h55; f_mosi[1] = 8'($urandom);
        run_frame(1, 5, "partial");

        for (int k = 0; k < 4; k++) f_mosi[k] = 8'($urandom);
        m_tready = 1'b0;
        model_pops(4);
        beats.delete();
        cs_n = 1'b0;
        wait_cyc(HALF);
        check_eq("rx_active", rx_active, 1);
        spi_bits(4, 0);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
        check_eq("ovr tvalid", m_tvalid, 1);
        check_eq("ovr held", {m_tlast, m_tuser, m_tdata}, {2'b11, f_mosi[0]});
        m_tready = 1'b1;
        wait_cyc(2);
        check_eq("ovr beats", beats.size(), 1);
        if (beats.size() > 0) check_eq("ovr beat", beats[0], {2'b11, f_mosi[0]});
        check_eq("ovr tvalid clr", m_tvalid, 0);

        for (int it = 0; it < 10; it++) begin
            np = $urandom_range(0, 3);
            for (int p = 0; p < np && tx_q.size() < DEPTH; p++) push_tx(8'($urandom));
            nf = $urandom_range(0, 4);
            np = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 8; k++) f_mosi[k] = 8'($urandom);
            run_frame(nf, np, "rand");
        end

        do_reset();
        for (int i = 0; i < DEPTH; i++) push_tx(8'h40 + 8'(i));
        check_eq("fifo full tready", s_tready, 0);
        cs_n = 1'b0;
        void'(tx_q.pop_front());
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            wait_cyc(1);
            if (s_tready) lat = i;
        end
        check_eq("pop tready latency", lat, SYNC + 1);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
`ifdef SPI_AXIS_TX_FLUSH_EN
        tx_q.delete();
`endif
        f_mosi[0] = 8'($urandom);
        run_frame(1, 0, "after_full");

        do_reset();
        push_tx(8'hAA);
        beats.delete();
        f_mosi[0] = 8'h96; f_mosi[1] = 8'h3D;
        cs_n = 1'b0;
        wait_cyc(HALF);
        spi_bits(0, 4);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        tx_q.delete();
        wait_cyc(HALF);
        spi_bits(2, 0);
        check_eq("rstlow miso0", f_miso[0], 8'hFF);
        check_eq("rstlow miso1", f_miso[1], 8'hFF);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
        check_eq("rstlow beats", beats.size(), 0);
        f_mosi[0] = 8'hC7; f_mosi[1] = 8'h18;
        run_frame(2, 0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_axis_bridge.md
# spi_axis_bridge

SPI mode-0 slave that converts host SPI transactions into the byte-wide AXI-Stream that feeds the wishbone command master, and returns that master's response stream on MISO. It sits directly upstream of the AXIS-to-wishbone path in the copter FPGA. It frames each chip-select assertion as one AXIS packet with `tlast`, and flags corrupted frames with `tuser`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `i_spi_sclk`, `i_spi_cs_n`, `i_spi_mosi`; must be ≥2.
- `TX_DEPTH`, default 16: TX FIFO depth in bytes; must be a power of 2, ≥2.

Ports:
- `i_clk`: input, 1 bit. System clock; the only clock.
- `i_reset`: input, 1 bit. Synchronous, active-high reset.
- `i_spi_sclk`, `i_spi_cs_n`, `i_spi_mosi`: input, 1 bit each. Asynchronous SPI pins.
- `o_spi_miso`: output, 1 bit. MSB-first response data.
- `m_axis_tdata`: output, 8 bits. Received byte.
- `m_axis_tkeep`: output, 1 bit. Constant 1.
- `m_axis_tvalid`: output, 1 bit.
- `m_axis_tready`: input, 1 bit.
- `m_axis_tlast`: output, 1 bit. Last byte of a CS frame.
- `m_axis_tuser`: output, 1 bit. Frame bad; valid only when `tlast` is 1.
- `s_axis_tdata`: input, 8 bits. Response byte.
- `s_axis_tkeep`, `s_axis_tlast`, `s_axis_tuser`: input, 1 bit each. Ignored.
- `s_axis_tvalid`: input, 1 bit.
- `s_axis_tready`: output, 1 bit. Deasserted when the TX FIFO is full.
- `o_rx_active`: output, 1 bit. Synchronized CS is low and the bridge is armed.

## Operation
- **Input synchronization.** Each SPI input passes through `SYNC_STAGES` flip-flops, plus one history flop for edge detection.
  - Sync reset values: sclk=0, cs_n=1, mosi=0.
- **Arming.**
  - After reset, the bridge is unarmed until synced CS is observed high.
  - While unarmed, edges are ignored and MISO stays 1.
- **CS fall** (armed):
  - bit counter cleared to 0;
  - `bad` cleared;
  - `pending_valid` cleared;
  - TX shift register loaded from the FIFO head (pop), or 0xFF if the FIFO is empty.
- **SCLK rising edge** (CS low):
  - `rx_shift <= {rx_shift[6:0], mosi}`;
  - bit counter increments modulo 8.
  - On wrap to 0, a byte is complete:
    - if `pending_valid`, push `pending` with `tlast=0`;
    - then `pending <= new byte` and set `pending_valid`.
- **SCLK falling edge** (CS low):
  - if the bit counter is 0 and this is not the first falling edge of the frame, load the TX shift register from the FIFO (or 0xFF);
  - otherwise shift the TX register left, filling with 1.
- `o_spi_miso` = TX shift register bit 7 while CS is low; 1 otherwise.
- **CS rise.**
  - If the bit counter ≠ 0, the partial byte is discarded and `bad` is set.
  - If `pending_valid`, push `pending` with `tlast=1` and `tuser=bad`.
  - With no pending byte, nothing is emitted (an empty or partial-only frame produces no beat).
- **Push onto `m_axis`.**
  - The output register loads when `!m_axis_tvalid || m_axis_tready`.
  - Otherwise the byte is dropped and `bad` is set.
  - A dropped `tlast` beat is instead forced out by overwriting the held beat's `tlast`/`tuser` with 1/1, so every frame closes.
- **TX FIFO.**
  - Standard circular buffer with pointers one bit wider than the address.
  - Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - A simultaneous push and pop is allowed at any occupancy except push-when-full.
  - Contents persist across CS frames (unless the `_EN` macro below is defined).

## Timing
- **Reset values:**
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser` = 0;
  - `m_axis_tdata` = 0;
  - `s_axis_tready` = 0 during reset, 1 from the first cycle after;
  - `o_spi_miso` = 1;
  - `o_rx_active` = 0;
  - FIFO empty.
- **Edge detect latency:** a pin change acts `SYNC_STAGES`+1 cycles after it occurs.
- **RX latency:**
  - a non-final byte appears on `m_axis` 1 cycle after the detected 8th rising edge of the *following* byte;
  - a final byte appears 1 cycle after the detected CS rise.
- **Clock ratio:** SCLK high and low times must each be ≥ `SYNC_STAGES`+3 `i_clk` cycles. MISO updates within `SYNC_STAGES`+2 cycles of the SCLK fall.
- **Reset mid-frame:** all state is cleared and the bridge is unarmed. No beat is emitted for the interrupted frame.

## Configuration
- **`SPI_AXIS_TX_FLUSH_EN` defined:** on every armed CS rise, the TX FIFO read pointer is set equal to the write pointer (FIFO emptied). Stale responses never leak into the next frame.
- **Undefined:** FIFO contents are retained across frames. This lets the host read a response in a later CS frame.

## Test plan
- **Single 3-byte frame.** Send 0xA5, 0x01, 0x7E with `m_axis_tready=1`.
  - Expect 3 beats: {A5, last 0}, {01, last 0}, {7E, last 1, user 0}.
- **Response on MISO.** Preload FIFO with 0x3C, 0xC3, then run a 3-byte frame.
  - MISO bytes are 3C, C3, FF.
  - `s_axis_tready` stays 1 throughout.
- **Partial byte.** Send 0x55 then 5 bits, then raise CS.
  - Expect one beat {55, last 1, user 1}.
- **Backpressure overrun.** `m_axis_tready=0` for a 4-byte frame.
  - Expect the first byte held, later bytes dropped, and the held beat rewritten to last 1, user 1.
- **FIFO full.** Push `TX_DEPTH` bytes with no SPI activity.
  - `s_axis_tready`=0 after the 16th accept; one pop re-asserts it the next cycle.
  - With `SPI_AXIS_TX_FLUSH_EN`, an empty CS pulse empties the FIFO.
- **Reset with CS held low.**
  - No beats are emitted and MISO=1 until CS goes high and then low again.
  - The next frame is then received normally.
